// File: rtl/cva6_regfile_pkg.sv
// Shared types and helpers for the LVT-based multi-port register file.
package cva6_regfile_pkg;

    typedef enum logic {
        INIT,
        READY
    } lvt_state_e;

    // Bank-select width; a single write port still needs a 1-bit LVT entry.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cva6_regfile_lvt_bank.sv
// One LUT-RAM bank: a single write port and NR_READ_PORTS asynchronous reads.
// The init override zeroes one word per cycle and takes priority over writes.
module cva6_regfile_lvt_bank #(
    parameter int unsigned DATA_WIDTH    = 64,
    parameter int unsigned NUM_WORDS     = 32,
    parameter int unsigned NR_READ_PORTS = 2,
    localparam int unsigned ADDR_WIDTH   = $clog2(NUM_WORDS)
) (
    input  logic                                clk_i,
    input  logic                                we_i,
    input  logic [ADDR_WIDTH-1:0]               waddr_i,
    input  logic [DATA_WIDTH-1:0]               wdata_i,
    input  logic                                init_i,
    input  logic [ADDR_WIDTH-1:0]               init_addr_i,
    input  logic [NR_READ_PORTS*ADDR_WIDTH-1:0] raddr_i,
    output logic [NR_READ_PORTS*DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem [NUM_WORDS];

    always_ff @(posedge clk_i) begin
        if (init_i) begin
            mem[init_addr_i] <= '0;
        end else if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    for (genvar gi = 0; gi < NR_READ_PORTS; gi++) begin : g_rd
        assign rdata_o[gi*DATA_WIDTH +: DATA_WIDTH] = mem[raddr_i[gi*ADDR_WIDTH +: ADDR_WIDTH]];
    end

endmodule

// File: rtl/cva6_regfile_lvt.sv
// Multi-port register file: one bank per write port, a live value table picks
// the bank holding the newest copy of each word. Optional bypass and read register.
module cva6_regfile_lvt
    import cva6_regfile_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 64,
    parameter int unsigned NUM_WORDS      = 32,
    parameter int unsigned NR_READ_PORTS  = 2,
    parameter int unsigned NR_WRITE_PORTS = 2,
    parameter bit          ZERO_REG_ZERO  = 1'b1,
    parameter bit          SYNC_READ      = 1'b0,
    parameter bit          WRITE_BYPASS   = 1'b1,
    parameter bit          INIT_ON_RESET  = 1'b1,
    localparam int unsigned ADDR_WIDTH    = $clog2(NUM_WORDS),
    localparam int unsigned LVT_WIDTH     = clog2_min1(NR_WRITE_PORTS)
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic [NR_READ_PORTS*ADDR_WIDTH-1:0]  raddr_i,
    output logic [NR_READ_PORTS*DATA_WIDTH-1:0]  rdata_o,
    input  logic [NR_WRITE_PORTS*ADDR_WIDTH-1:0] waddr_i,
    input  logic [NR_WRITE_PORTS*DATA_WIDTH-1:0] wdata_i,
    input  logic [NR_WRITE_PORTS-1:0]            we_i,
    output logic                                 init_busy_o,
    output logic                                 conflict_o
);

    localparam lvt_state_e RESET_STATE = INIT_ON_RESET ? INIT : READY;

    lvt_state_e                          state_reg, state_next;
    logic [ADDR_WIDTH-1:0]               cnt_reg, cnt_next;
    logic                                init_busy;
    logic [NR_WRITE_PORTS-1:0]           we_eff;
    logic [ADDR_WIDTH-1:0]               waddr [NR_WRITE_PORTS];
    logic [DATA_WIDTH-1:0]               wdata [NR_WRITE_PORTS];
    logic [LVT_WIDTH-1:0]                lvt_reg [NUM_WORDS];
    logic [NR_READ_PORTS*DATA_WIDTH-1:0] bank_rdata [NR_WRITE_PORTS];
    logic                                conflict_reg, conflict_next;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= RESET_STATE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        if (state_reg == INIT) begin
            cnt_next = cnt_reg + 1'b1;
            if (cnt_reg == ADDR_WIDTH'(NUM_WORDS - 1)) begin
                state_next = READY;
                cnt_next   = '0;
            end
        end
    end

    assign init_busy   = (state_reg == INIT);
    assign init_busy_o = init_busy;

    for (genvar gi = 0; gi < NR_WRITE_PORTS; gi++) begin : g_wr
        assign waddr[gi]  = waddr_i[gi*ADDR_WIDTH +: ADDR_WIDTH];
        assign wdata[gi]  = wdata_i[gi*DATA_WIDTH +: DATA_WIDTH];
        assign we_eff[gi] = we_i[gi] && !init_busy && !(ZERO_REG_ZERO && (waddr[gi] == '0));

        cva6_regfile_lvt_bank #(
            .DATA_WIDTH    (DATA_WIDTH),
            .NUM_WORDS     (NUM_WORDS),
            .NR_READ_PORTS (NR_READ_PORTS)
        ) i_bank (
            .clk_i       (clk_i),
            .we_i        (we_eff[gi]),
            .waddr_i     (waddr[gi]),
            .wdata_i     (wdata[gi]),
            .init_i      (init_busy),
            .init_addr_i (cnt_reg),
            .raddr_i     (raddr_i),
            .rdata_o     (bank_rdata[gi])
        );
    end

    // Later loop iterations override earlier ones, so the highest port wins a tie.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_WORDS; i++) begin
                lvt_reg[i] <= '0;
            end
        end else if (init_busy) begin
            lvt_reg[cnt_reg] <= '0;
        end else begin
            for (int j = 0; j < NR_WRITE_PORTS; j++) begin
                if (we_eff[j]) begin
                    lvt_reg[waddr[j]] <= LVT_WIDTH'(j);
                end
            end
        end
    end

    always_comb begin
        conflict_next = 1'b0;
        for (int i = 0; i < NR_WRITE_PORTS; i++) begin
            for (int j = i + 1; j < NR_WRITE_PORTS; j++) begin
                if (we_eff[i] && we_eff[j] && (waddr[i] == waddr[j])) begin
                    conflict_next = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            conflict_reg <= 1'b0;
        end else begin
            conflict_reg <= conflict_next;
        end
    end

    assign conflict_o = conflict_reg;

    for (genvar gi = 0; gi < NR_READ_PORTS; gi++) begin : g_rd
        logic [ADDR_WIDTH-1:0] raddr;
        logic [DATA_WIDTH-1:0] rd_comb;

        assign raddr = raddr_i[gi*ADDR_WIDTH +: ADDR_WIDTH];

        always_comb begin
            rd_comb = bank_rdata[lvt_reg[raddr]][gi*DATA_WIDTH +: DATA_WIDTH];
            if (WRITE_BYPASS) begin
                for (int j = 0; j < NR_WRITE_PORTS; j++) begin
                    if (we_eff[j] && (waddr[j] == raddr)) begin
                        rd_comb = wdata[j];
                    end
                end
            end
            if ((ZERO_REG_ZERO && (raddr == '0)) || init_busy) begin
                rd_comb = '0;
            end
        end

        if (SYNC_READ) begin : g_sync
            logic [DATA_WIDTH-1:0] rdata_reg;
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    rdata_reg <= '0;
                end else begin
                    rdata_reg <= rd_comb;
                end
            end
            assign rdata_o[gi*DATA_WIDTH +: DATA_WIDTH] = rdata_reg;
        end else begin : g_comb
            assign rdata_o[gi*DATA_WIDTH +: DATA_WIDTH] = rd_comb;
        end
    end

endmodule

// File: tb/tb_cva6_regfile_lvt.sv
// Bench for cva6_regfile_lvt: default (combinational, bypass) instance plus a
// registered-read, no-bypass instance for latency and mid-init reset cases.
module tb_cva6_regfile_lvt;

    logic clk;
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Default-parameter instance
    logic         rst_n;
    logic [9:0]   raddr, waddr;
    logic [127:0] wdata;
    logic [1:0]   we;
    logic [127:0] rdata;
    logic         busy, conf;

    cva6_regfile_lvt dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .raddr_i     (raddr),
        .rdata_o     (rdata),
        .waddr_i     (waddr),
        .wdata_i     (wdata),
        .we_i        (we),
        .init_busy_o (busy),
        .conflict_o  (conf)
    );

    // Registered-read, no-bypass instance
    logic         rst_s;
    logic [9:0]   raddr_s, waddr_s;
    logic [127:0] wdata_s;
    logic [1:0]   we_s;
    logic [127:0] rdata_s;
    logic         busy_s, conf_s;

    cva6_regfile_lvt #(
        .SYNC_READ    (1'b1),
        .WRITE_BYPASS (1'b0)
    ) dut_s (
        .clk_i       (clk),
        .rst_ni      (rst_s),
        .raddr_i     (raddr_s),
        .rdata_o     (rdata_s),
        .waddr_i     (waddr_s),
        .wdata_i     (wdata_s),
        .we_i        (we_s),
        .init_busy_o (busy_s),
        .conflict_o  (conf_s)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: architectural contents after all completed writes.
    logic [63:0] model [32];

    task automatic model_write(input logic [1:0] w, input logic [4:0] a0, input logic [63:0] d0,
                               input logic [4:0] a1, input logic [63:0] d1);
        if (w[0] && a0 != 5'd0) model[a0] = d0;
        if (w[1] && a1 != 5'd0) model[a1] = d1;
    endtask

    function automatic logic [63:0] exp_read(input logic [4:0] r, input logic [1:0] w,
                                             input logic [4:0] a0, input logic [63:0] d0,
                                             input logic [4:0] a1, input logic [63:0] d1);
        logic [63:0] v;
        if (r == 5'd0) return 64'd0;
        v = model[r];
        if (w[0] && a0 == r) v = d0;
        if (w[1] && a1 == r) v = d1;
        return v;
    endfunction

    task automatic drive(input logic [1:0] w, input logic [4:0] a0, input logic [63:0] d0,
                         input logic [4:0] a1, input logic [63:0] d1,
                         input logic [4:0] r0, input logic [4:0] r1);
        we    = w;
        waddr = {a1, a0};
        wdata = {d1, d0};
        raddr = {r1, r0};
    endtask

    typedef struct {
        logic [1:0]  we;
        logic [4:0]  wa0;
        logic [63:0] wd0;
        logic [4:0]  wa1;
        logic [63:0] wd1;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [63:0] e0;
        logic [63:0] e1;
        logic        ec;
    } vec_t;

    vec_t vecs [14];

    initial begin
        int          n;
        logic [1:0]  rw;
        logic [4:0]  ra0, ra1, ra_0, ra_1;
        logic [63:0] rd0, rd1;
        logic        prev_conf;

        vecs[0]  = '{2'b01, 5'd5,  64'hA5,   5'd0,  64'h0,  5'd5,  5'd3,  64'hA5,   64'h0,  1'b0};
        vecs[1]  = '{2'b00, 5'd0,  64'h0,    5'd0,  64'h0,  5'd5,  5'd0,  64'hA5,   64'h0,  1'b0};
        vecs[2]  = '{2'b11, 5'd7,  64'h11,   5'd7,  64'h22, 5'd7,  5'd5,  64'h22,   64'hA5, 1'b0};
        vecs[3]  = '{2'b00, 5'd0,  64'h0,    5'd0,  64'h0,  5'd7,  5'd7,  64'h22,   64'h22, 1'b1};
        vecs[4]  = '{2'b00, 5'd0,  64'h0,    5'd0,  64'h0,  5'd7,  5'd5,  64'h22,   64'hA5, 1'b0};
        vecs[5]  = '{2'b10, 5'd0,  64'h0,    5'd3,  64'h33, 5'd3,  5'd3,  64'h33,   64'h33, 1'b0};
        vecs[6]  = '{2'b01, 5'd0,  64'hFF,   5'd0,  64'h0,  5'd0,  5'd5,  64'h0,    64'hA5, 1'b0};
        vecs[7]  = '{2'b00, 5'd0,  64'h0,    5'd0,  64'h0,  5'd0,  5'd5,  64'h0,    64'hA5, 1'b0};
        vecs[8]  = '{2'b11, 5'd9,  64'h1,    5'd10, 64'h2,  5'd9,  5'd10, 64'h1,    64'h2,  1'b0};
        vecs[9]  = '{2'b00, 5'd0,  64'h0,    5'd0,  64'h0,  5'd9,  5'd10, 64'h1,    64'h2,  1'b0};
        vecs[10] = '{2'b11, 5'd12, 64'h44,   5'd0,  64'h55, 5'd12, 5'd0,  64'h44,   64'h0,  1'b0};
        vecs[11] = '{2'b01, 5'd3,  64'h66,   5'd0,  64'h0,  5'd3,  5'd7,  64'h66,   64'h22, 1'b0};
        vecs[12] = '{2'b00, 5'd0,  64'h0,    5'd0,  64'h0,  5'd3,  5'd7,  64'h66,   64'h22, 1'b0};
        vecs[13] = '{2'b01, 5'd5,  64'hBEEF, 5'd0,  64'h0,  5'd5,  5'd12, 64'hBEEF, 64'h44, 1'b0};

        for (int i = 0; i < 32; i++) model[i] = 64'd0;

        rst_n = 1'b0; rst_s = 1'b0;
        drive(2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 5'd0, 5'd0);
        we_s = 2'b00; waddr_s = '0; wdata_s = '0; raddr_s = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst busy", 64'(busy), 64'd1);
        check("rst conflict", 64'(conf), 64'd0);
        check("rst sync rdata0", rdata_s[63:0], 64'd0);
        check("rst sync rdata1", rdata_s[127:64], 64'd0);
        check("rst sync busy", 64'(busy_s), 64'd1);

        // ---------------- default instance: init length and zeroed contents
        @(posedge clk); #1;
        rst_n = 1'b1;
        n = 0;
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            if (!busy) break;
            n++;
        end
        check("init busy cycles", 64'(n), 64'd32);
        @(posedge clk); #1;
        for (int a = 0; a < 32; a++) begin
            drive(2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 5'(a), 5'(31 - a));
            @(negedge clk);
            check($sformatf("init zero rd0 a%0d", a), rdata[63:0], 64'd0);
            check($sformatf("init zero rd1 a%0d", 31 - a), rdata[127:64], 64'd0);
            @(posedge clk); #1;
        end

        // ---------------- directed vector table
        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].we, vecs[i].wa0, vecs[i].wd0, vecs[i].wa1, vecs[i].wd1, vecs[i].ra0, vecs[i].ra1);
            @(negedge clk);
            check($sformatf("vec%0d rd0", i), rdata[63:0], vecs[i].e0);
            check($sformatf("vec%0d rd1", i), rdata[127:64], vecs[i].e1);
            check($sformatf("vec%0d conflict", i), 64'(conf), 64'(vecs[i].ec));
            model_write(vecs[i].we, vecs[i].wa0, vecs[i].wd0, vecs[i].wa1, vecs[i].wd1);
            @(posedge clk); #1;
        end

        // ---------------- randomized traffic against the model
        prev_conf = 1'b0;
        for (int i = 0; i < 300; i++) begin
            rw  = 2'($urandom_range(0, 3));
            ra0 = 5'($urandom_range(1, 31));
            ra1 = ($urandom_range(0, 3) == 0) ? ra0 : 5'($urandom_range(1, 31));
            rd0 = {$urandom, $urandom};
            rd1 = {$urandom, $urandom};
            ra_0 = ($urandom_range(0, 2) == 0) ? ra0 : 5'($urandom_range(0, 31));
            ra_1 = ($urandom_range(0, 2) == 0) ? ra1 : 5'($urandom_range(0, 31));
            drive(rw, ra0, rd0, ra1, rd1, ra_0, ra_1);
            @(negedge clk);
            check($sformatf("rand%0d rd0 a%0d", i, ra_0), rdata[63:0], exp_read(ra_0, rw, ra0, rd0, ra1, rd1));
            check($sformatf("rand%0d rd1 a%0d", i, ra_1), rdata[127:64], exp_read(ra_1, rw, ra0, rd0, ra1, rd1));
            check($sformatf("rand%0d conflict", i), 64'(conf), 64'(prev_conf));
            prev_conf = (rw == 2'b11) && (ra0 == ra1);
            model_write(rw, ra0, rd0, ra1, rd1);
            @(posedge clk); #1;
        end
        drive(2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 5'd0, 5'd0);

        // ---------------- registered-read instance: mid-init reset
        rst_s   = 1'b1;
        we_s    = 2'b11;
        waddr_s = {5'd6, 5'd4};
        wdata_s = {64'h6666, 64'hDEAD};
        repeat (10) @(posedge clk);
        #1;
        rst_s = 1'b0;
        @(negedge clk);
        check("sync midreset busy", 64'(busy_s), 64'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_s = 1'b1;
        n = 0;
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            if (!busy_s) break;
            n++;
        end
        we_s = 2'b00;
        check("sync reinit busy cycles", 64'(n), 64'd32);
        raddr_s = {5'd6, 5'd4};
        @(posedge clk); #1;
        check("sync init-write dropped a4", rdata_s[63:0], 64'd0);
        check("sync init-write dropped a6", rdata_s[127:64], 64'd0);

        // ---------------- registered-read instance: latency and no bypass
        we_s    = 2'b01;
        waddr_s = {5'd0, 5'd5};
        wdata_s = {64'd0, 64'hA5};
        raddr_s = {5'd4, 5'd5};
        @(posedge clk); #1;
        we_s = 2'b00;
        check("sync prewrite rd0", rdata_s[63:0], 64'd0);
        @(posedge clk); #1;
        check("sync postwrite rd0", rdata_s[63:0], 64'hA5);
        check("sync rd1 a4", rdata_s[127:64], 64'd0);
        raddr_s = {5'd5, 5'd4};
        #2;
        check("sync hold rd0", rdata_s[63:0], 64'hA5);
        @(posedge clk); #1;
        check("sync latency rd0", rdata_s[63:0], 64'd0);
        check("sync latency rd1", rdata_s[127:64], 64'hA5);
        check("sync conflict idle", 64'(conf_s), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
